// File: rtl/spla43_preimage_scanner.sv
// Enumerates the on-set of the spla output-43 cone: sweeps a 16-bit range one
// candidate per cycle and streams every vector with y0 = 1 over valid/ready.
module spla43_preimage_scanner #(
    parameter int W     = 16,
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     range_lo,
    input  logic [W-1:0]     range_hi,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_vec,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_reg;
    logic [W:0]     cursor_reg;
    logic [W-1:0]   hi_reg;
    logic           hit;
    logic           cursor_at_hi;

    // Output-43 cone; x12..x15 do not participate.
    function automatic logic f43(input logic [W-1:0] v);
        logic sel_hi;
        logic sel_lo;
        sel_hi = ~v[7] | (~v[10] & ~v[11]);
        sel_lo = v[7] & (v[8] ^ v[9]);
        return ~v[0] & ~v[1] & ~v[2] & ~v[3] & ~v[4] & v[6] & (v[5] ? sel_hi : sel_lo);
    endfunction

    assign hit          = f43(cursor_reg[W-1:0]);
    // The extra cursor bit keeps a range ending at all-ones from wrapping.
    assign cursor_at_hi = (cursor_reg == {1'b0, hi_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cursor_reg  <= '0;
            hi_reg      <= '0;
            m_valid     <= 1'b0;
            m_vec       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
        end else if (abort) begin
            state_reg <= IDLE;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        hi_reg      <= range_hi;
                        cursor_reg  <= {1'b0, range_lo};
                        match_count <= '0;
                        if (range_lo > range_hi) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= SCAN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (hit) begin
                        m_vec     <= cursor_reg[W-1:0];
                        m_valid   <= 1'b1;
                        state_reg <= HOLD;
                    end else if (cursor_at_hi) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cursor_reg <= cursor_reg + 1'b1;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid     <= 1'b0;
                        match_count <= match_count + 1'b1;
                        if (cursor_at_hi) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            cursor_reg <= cursor_reg + 1'b1;
                            state_reg  <= SCAN;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
